// File: rtl/countdown_timer_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_if
// Groups the keypad / control strobes and the display / status outputs of the
// countdown timer into one bundle.
//   master : drives keypad and control inputs, observes display and status
//   slave  : the timer itself
// Signals:
//   digit[3:0], digit_valid     keypad BCD digit and its one-cycle qualifier
//   start, stop, clear          one-cycle control strobes
//   door_open                   door sensor level (1 = open)
//   min, sec_tens, sec_ones     BCD display digits m:ss
//   running                     magnetron enable
//   done                        countdown finished, held until clear
// ---------------------------------------------------------------------------
interface countdown_timer_if;
    logic [3:0] digit;
    logic       digit_valid;
    logic       start;
    logic       stop;
    logic       clear;
    logic       door_open;
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;

    modport master (
        output digit, digit_valid, start, stop, clear, door_open,
        input  min, sec_tens, sec_ones, running, done
    );

    modport slave (
        input  digit, digit_valid, start, stop, clear, door_open,
        output min, sec_tens, sec_ones, running, done
    );
endinterface

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
// Microwave-style m:ss countdown timer with keypad entry, quick start,
// pause/resume and a latched completion flag.
// Ports:
//   clock       sole clock, rising edge
//   reset_n     synchronous active-low reset
//   bus         countdown_timer_if.slave (keypad/control in, display/status out)
// Parameters:
//   TICKS_PER_SEC  clock cycles per timer second (>= 2)
//   QUICK_SECS     seconds loaded by a start at 0:00 in IDLE (1..59)
// Build option:
//   DOOR_INTERLOCK_EN  when defined, an open door pauses a running count and
//                      blocks start; when undefined door_open is ignored.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for entry/start, prescaler held at 0
// ST_RUNNING | counting down, running=1
// ST_PAUSED  | count frozen, entry allowed, start resumes
// ST_DONE    | reached 0:00, done=1 until clear
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int QUICK_SECS    = 30
) (
    input  logic                clock,
    input  logic                reset_n,
    countdown_timer_if.slave    bus
);

    localparam int             PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]  PRESC_TC   = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]     QUICK_TENS = 4'(QUICK_SECS / 10);
    localparam logic [3:0]     QUICK_ONES = 4'(QUICK_SECS % 10);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PAUSED,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [3:0]      r_min;
    logic [3:0]      r_sec_tens;
    logic [3:0]      r_sec_ones;
    logic            r_running;
    logic            r_done;

    logic            w_door_open;
    logic            w_start_ok;
    logic            w_digit_ok;
    logic            w_time_zero;
    logic            w_wrap;
    logic [3:0]      w_dec_min;
    logic [3:0]      w_dec_tens;
    logic [3:0]      w_dec_ones;
    logic            w_dec_zero;

`ifdef DOOR_INTERLOCK_EN
    assign w_door_open = bus.door_open;
`else
    assign w_door_open = 1'b0;
`endif

    assign w_start_ok  = bus.start && !w_door_open;
    // sec_ones must stay 0-5 so it can legally shift into the tens position
    assign w_digit_ok  = bus.digit_valid && (bus.digit <= 4'd9) && (r_sec_ones <= 4'd5);
    assign w_time_zero = (r_min == 4'd0) && (r_sec_tens == 4'd0) && (r_sec_ones == 4'd0);
    assign w_wrap      = (r_presc == PRESC_TC);

    // BCD borrow chain for one elapsed second
    always_comb begin
        w_dec_min  = r_min;
        w_dec_tens = r_sec_tens;
        w_dec_ones = r_sec_ones;
        if (r_sec_ones != 4'd0) begin
            w_dec_ones = r_sec_ones - 4'd1;
        end else begin
            w_dec_ones = 4'd9;
            if (r_sec_tens != 4'd0) begin
                w_dec_tens = r_sec_tens - 4'd1;
            end else begin
                w_dec_tens = 4'd5;
                w_dec_min  = r_min - 4'd1;
            end
        end
        w_dec_zero = (r_min == 4'd0) && (r_sec_tens == 4'd0) && (r_sec_ones == 4'd1);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_min      <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else if (bus.clear) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_min      <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSED: begin
                    r_presc <= '0;
                    if (w_start_ok) begin
                        if (r_state == ST_IDLE && w_time_zero) begin
                            r_sec_tens <= QUICK_TENS;
                            r_sec_ones <= QUICK_ONES;
                        end
                        r_state   <= ST_RUNNING;
                        r_running <= 1'b1;
                    end else if (w_digit_ok) begin
                        r_min      <= r_sec_tens;
                        r_sec_tens <= r_sec_ones;
                        r_sec_ones <= bus.digit;
                    end
                end
                ST_RUNNING: begin
                    // door and stop both pause and suppress a coincident wrap
                    if (w_door_open || bus.stop) begin
                        r_state   <= ST_PAUSED;
                        r_running <= 1'b0;
                        r_presc   <= '0;
                    end else if (w_wrap) begin
                        r_presc    <= '0;
                        r_min      <= w_dec_min;
                        r_sec_tens <= w_dec_tens;
                        r_sec_ones <= w_dec_ones;
                        if (w_dec_zero) begin
                            r_state   <= ST_DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                default: begin
                    r_presc <= '0;
                end
            endcase
        end
    end

    assign bus.min      = r_min;
    assign bus.sec_tens = r_sec_tens;
    assign bus.sec_ones = r_sec_ones;
    assign bus.running  = r_running;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int TPS   = 4;
    localparam int QUICK = 30;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE = 3;

    logic clock;
    logic reset_n;
    int   n_total;
    int   n_bad;

    // reference model: remaining time in seconds, mode, cycles into current second
    int   m_t;
    int   m_mode;
    int   m_pc;

    countdown_timer_if bus ();

    countdown_timer #(
        .TICKS_PER_SEC (TPS),
        .QUICK_SECS    (QUICK)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit door_blocks();
`ifdef DOOR_INTERLOCK_EN
        return bus.door_open;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        int tens;
        int ones;
        if (!reset_n || bus.clear) begin
            m_mode = M_IDLE;
            m_t    = 0;
            m_pc   = 0;
        end else if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
            m_pc = 0;
            if (bus.start && !door_blocks()) begin
                if (m_mode == M_IDLE && m_t == 0) m_t = QUICK;
                m_mode = M_RUN;
            end else if (bus.digit_valid && bus.digit <= 9 && (m_t % 10) <= 5) begin
                tens = (m_t % 60) / 10;
                ones = m_t % 10;
                m_t  = tens * 60 + ones * 10 + int'(bus.digit);
            end
        end else if (m_mode == M_RUN) begin
            if (door_blocks() || bus.stop) begin
                m_mode = M_PAUSE;
                m_pc   = 0;
            end else if (m_pc == TPS - 1) begin
                m_pc = 0;
                // 0:00 borrows into a 4-bit minute digit: 15:59
                m_t  = (m_t == 0) ? (15 * 60 + 59) : (m_t - 1);
                if (m_t == 0) m_mode = M_DONE;
            end else begin
                m_pc++;
            end
        end
    endtask

    task automatic compare_all();
        check("min",      32'(bus.min),      32'((m_t / 60) % 16));
        check("sec_tens", 32'(bus.sec_tens), 32'((m_t % 60) / 10));
        check("sec_ones", 32'(bus.sec_ones), 32'(m_t % 10));
        check("running",  32'(bus.running),  32'(m_mode == M_RUN));
        check("done",     32'(bus.done),     32'(m_mode == M_DONE));
    endtask

    task automatic idle_inputs();
        bus.digit       = 4'd0;
        bus.digit_valid = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.clear       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
        idle_inputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic key(input logic [3:0] d);
        bus.digit       = d;
        bus.digit_valid = 1'b1;
        tick();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
    endtask

    function automatic logic [11:0] disp();
        return {bus.min, bus.sec_tens, bus.sec_ones};
    endfunction

    initial begin
        n_total = 0;
        n_bad   = 0;
        m_t     = 0;
        m_mode  = M_IDLE;
        m_pc    = 0;
        bus.door_open = 1'b0;
        idle_inputs();
        reset_n = 1'b0;
        #2;
        ticks(2);
        check("rst_disp", 32'(disp()), 32'h000);
        check("rst_run",  32'(bus.running), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset_n = 1'b1;

        // entry 1,3,0 then start
        key(4'd1); key(4'd3); key(4'd0);
        check("entry_130", 32'(disp()), 32'h130);
        do_start();
        check("start_run", 32'(bus.running), 32'd1);
        ticks(3);
        check("pre_tick_130", 32'(disp()), 32'h130);
        tick();
        check("first_dec_129", 32'(disp()), 32'h129);

        // borrow chains
        do_clear();
        key(4'd1); key(4'd0); key(4'd0);
        do_start();
        ticks(4);
        check("borrow_059", 32'(disp()), 32'h059);
        do_clear();
        key(4'd1); key(4'd0);
        do_start();
        ticks(4);
        check("borrow_009", 32'(disp()), 32'h009);

        // completion
        do_clear();
        key(4'd1);
        do_start();
        ticks(4);
        check("done_disp", 32'(disp()), 32'h000);
        check("done_flag", 32'(bus.done), 32'd1);
        check("done_run",  32'(bus.running), 32'd0);
        do_start();
        check("done_start_ign", 32'(bus.done), 32'd1);
        do_clear();
        check("clear_done", 32'(bus.done), 32'd0);

        // quick start, stop coincident with wrap
        do_start();
        check("quick_030", 32'(disp()), 32'h030);
        ticks(3);
        bus.stop = 1'b1;
        tick();
        check("stop_wrap_030", 32'(disp()), 32'h030);
        check("stop_paused",   32'(bus.running), 32'd0);
        do_start();
        check("resume_run", 32'(bus.running), 32'd1);
        ticks(3);
        check("resume_hold_030", 32'(disp()), 32'h030);
        tick();
        check("resume_029", 32'(disp()), 32'h029);

        // entry guard
        do_clear();
        key(4'd7);
        key(4'd5);
        check("guard_ones7", 32'(disp()), 32'h007);
        do_clear();
        key(4'd3);
        key(4'd12);
        check("guard_digit12", 32'(disp()), 32'h003);

        // door interlock
        do_clear();
        key(4'd4); key(4'd5);
        do_start();
        bus.door_open = 1'b1;
        tick();
`ifdef DOOR_INTERLOCK_EN
        check("door_pause_run", 32'(bus.running), 32'd0);
        check("door_pause_045", 32'(disp()), 32'h045);
        do_start();
        check("door_start_ign", 32'(bus.running), 32'd0);
`else
        check("door_ignored", 32'(bus.running), 32'd1);
        do_start();
        check("door_start_ok", 32'(bus.running), 32'd1);
`endif
        bus.door_open = 1'b0;
        do_clear();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 999));
            reset_n = (r < 4) ? 1'b0 : 1'b1;
            bus.clear       = ($urandom_range(0, 99) < 2);
            bus.stop        = ($urandom_range(0, 99) < 4);
            bus.start       = ($urandom_range(0, 99) < 6);
            bus.digit_valid = ($urandom_range(0, 99) < 20);
            bus.digit       = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 2) bus.door_open = ~bus.door_open;
            tick();
        end
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
